// File: rtl/sti_load_scheduler.sv
// sti_load_scheduler: round-robin sharing of one STI_DAC serializer; define STI_SCHED_WDOG_EN for the WAIT watchdog
module sti_load_scheduler #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int GAP_CYC  = 1,
  parameter int WDOG_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [2*NREQ-1:0]    req_length,
  input  logic [NREQ-1:0]      req_fill,
  input  logic [NREQ-1:0]      req_msb,
  input  logic [NREQ-1:0]      req_low,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      gnt,
  input  logic                 so_valid,
  input  logic                 oem_finish,
  output logic                 load,
  output logic [15:0]          pi_data,
  output logic [1:0]           pi_length,
  output logic                 pi_fill,
  output logic                 pi_msb,
  output logic                 pi_low,
  output logic                 pi_end,
  output logic                 busy,
  output logic [IDW-1:0]       cur_id,
  output logic                 sched_done,
  output logic                 wdog_err
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, GAP, END, DONE} state_t;
  state_t state, after_burst;
  logic [IDW-1:0] rr_ptr, win, idx;
  logic found;
  logic [NREQ-1:0] last_mask;
  logic [5:0] bit_cnt, tgt;
  logic [2:0] gap_cnt, len_p1;
  assign after_burst = (GAP_CYC == 0) ? IDLE : GAP;
  assign len_p1 = {1'b0, pi_length} + 3'd1;
  assign tgt = {len_p1, 3'b000};
  assign busy = (state != IDLE) && (state != DONE);
  // first pending requester after the last winner, wrapping mod NREQ
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
`ifdef STI_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign wdog_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= IDW'(NREQ - 1);
      last_mask  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      gnt        <= '0;
      load       <= 1'b0;
      pi_data    <= '0;
      pi_length  <= '0;
      pi_fill    <= 1'b0;
      pi_msb     <= 1'b0;
      pi_low     <= 1'b0;
      pi_end     <= 1'b0;
      cur_id     <= '0;
      sched_done <= 1'b0;
`ifdef STI_SCHED_WDOG_EN
      wdog_err   <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      last_mask <= last_mask | req_last;
      gnt       <= '0;
      load      <= 1'b0;
      case (state)
        IDLE:
          if (|req) begin
            pi_data   <= req_data[16*win +: 16];
            pi_length <= req_length[2*win +: 2];
            pi_fill   <= req_fill[win];
            pi_msb    <= req_msb[win];
            pi_low    <= req_low[win];
            gnt[win]  <= 1'b1;
            cur_id    <= win;
            rr_ptr    <= win;
            state     <= LOAD;
          end else if (&last_mask) begin
            pi_end <= 1'b1;
            state  <= END;
          end
        LOAD: begin
          load    <= 1'b1;
          bit_cnt <= '0;
          gap_cnt <= '0;
          state   <= WAIT;
`ifdef STI_SCHED_WDOG_EN
          wd_cnt  <= '0;
`endif
        end
        WAIT:
          if (so_valid) begin
            bit_cnt <= 6'd1;
            state   <= SHIFT;
          end
`ifdef STI_SCHED_WDOG_EN
          else if (wd_cnt == WDW'(WDOG_CYC - 1)) begin
            wdog_err <= 1'b1;
            state    <= after_burst;
          end else wd_cnt <= wd_cnt + 1'b1;
`endif
        SHIFT:
          if (so_valid) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt + 6'd1 == tgt) state <= after_burst;
          end
        GAP:
          if (gap_cnt == 3'(GAP_CYC - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 3'd1;
        END:
          if (oem_finish) begin
            sched_done <= 1'b1;
            state      <= DONE;
          end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sti_load_scheduler.sv
// tb_sti_load_scheduler: directed stimulus with a grant scoreboard and a serializer model
module tb_sti_load_scheduler;
  localparam int GAP = 1;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req, req_fill, req_msb, req_low, req_last, gnt;
  logic [63:0] req_data;
  logic [7:0] req_length;
  logic so_valid, oem_finish, load, pi_fill, pi_msb, pi_low, pi_end, busy, sched_done, wdog_err;
  logic [15:0] pi_data;
  logic [1:0] pi_length, cur_id;
  sti_load_scheduler #(.NREQ(4), .IDW(2), .GAP_CYC(GAP), .WDOG_CYC(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_length(req_length),
    .req_fill(req_fill), .req_msb(req_msb), .req_low(req_low), .req_last(req_last),
    .gnt(gnt), .so_valid(so_valid), .oem_finish(oem_finish), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .cur_id(cur_id),
    .sched_done(sched_done), .wdog_err(wdog_err));
  typedef struct {int id; logic [15:0] data; logic [1:0] len; logic [2:0] flags;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic [15:0] d_r [4];
  logic [1:0] l_r [4];
  logic [2:0] f_r [4];
  int passed = 0, total = 0;
  bit ser_en = 1'b1, wdog_mode = 1'b0;
  always_comb begin
    req_data = '0;
    req_length = '0;
    req_fill = '0;
    req_msb = '0;
    req_low = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[16*i +: 16] = d_r[i];
      req_length[2*i +: 2] = l_r[i];
      {req_fill[i], req_msb[i], req_low[i]} = f_r[i];
    end
  end
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask
  task automatic push(input int id);
    exp_t e;
    e.id = id;
    e.data = d_r[id];
    e.len = l_r[id];
    e.flags = f_r[id];
    exp_q.push_back(e);
  endtask
  task automatic wait_gnt();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (gnt != 0) break;
    end
    chk("gnt_seen", int'(gnt != 0), 1);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("idle_seen", int'(busy), 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_pi"}, int'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 0);
    chk({tag, "_end_done"}, int'({pi_end, sched_done, wdog_err}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cur_id"}, int'(cur_id), 0);
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset_checks(tag);
    reset = 1'b0;
  endtask
  // serializer model: so_valid for (len+1)*8 cycles with one hole after the third bit
  initial begin
    so_valid = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (load && ser_en && !reset) begin
        for (int i = 0; i < (int'(pi_length) + 1) * 8; i++) begin
          if (i == 3) begin
            so_valid = 1'b0;
            @(posedge clk); #2;
          end
          if (reset) break;
          so_valid = 1'b1;
          @(posedge clk); #2;
          if (reset) break;
        end
        so_valid = 1'b0;
      end
    end
  end
  bit load_due = 1'b0, in_burst = 1'b0, prev_busy = 1'b0;
  int sv_cnt = 0, post_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      load_due = 1'b0;
      in_burst = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (load_due) begin
        chk("load_after_gnt", int'(load), 1);
        chk("pi_data", int'(pi_data), int'(cur.data));
        chk("pi_length", int'(pi_length), int'(cur.len));
        chk("pi_flags", int'({pi_fill, pi_msb, pi_low}), int'(cur.flags));
        load_due = 1'b0;
        in_burst = 1'b1;
        sv_cnt = 0;
        post_cnt = 0;
      end else if (load) chk("spurious_load", int'(load), 0);
      if (gnt != 0) begin
        if (exp_q.size() == 0) chk("unexpected_gnt", int'(gnt), 0);
        else begin
          cur = exp_q.pop_front();
          chk("gnt", int'(gnt), 1 << cur.id);
          chk("cur_id", int'(cur_id), cur.id);
          load_due = 1'b1;
        end
      end
      if (in_burst && busy) begin
        if (so_valid) begin
          sv_cnt++;
          post_cnt = 0;
        end else if (sv_cnt > 0) post_cnt++;
      end
      if (in_burst && prev_busy && !busy) begin
        if (wdog_mode) chk("wdog_err_set", int'(wdog_err), 1);
        else begin
          chk("burst_bits", sv_cnt, (int'(cur.len) + 1) * 8);
          chk("gap_cycles", post_cnt, GAP);
        end
        chk("cur_id_end", int'(cur_id), cur.id);
        in_burst = 1'b0;
      end
      prev_busy = busy;
    end
  end
  initial begin
    int ng;
    req = '0;
    req_last = '0;
    oem_finish = 1'b0;
    d_r[0] = 16'hA5C3; l_r[0] = 2'd1; f_r[0] = 3'b101;
    d_r[1] = 16'h1234; l_r[1] = 2'd0; f_r[1] = 3'b010;
    d_r[2] = 16'hBEEF; l_r[2] = 2'd2; f_r[2] = 3'b111;
    d_r[3] = 16'h0F0F; l_r[3] = 2'd3; f_r[3] = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst0");
    reset = 1'b0;
    req = 4'b0001; push(0); wait_gnt(); req = '0; wait_idle();
    req = 4'b1111;
    push(1); push(2); push(3); push(0); push(1);
    repeat (5) wait_gnt();
    req = '0;
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);
    for (int L = 0; L < 4; L++) begin
      l_r[2] = 2'(L);
      req = 4'b0100; push(2); wait_gnt(); req = '0; wait_idle();
    end
    req = 4'b0010; req_last = 4'b1111; push(1); wait_gnt();
    req = '0; req_last = '0;
    chk("pi_end_before_end", int'(pi_end), 0);
    wait_idle();
    @(posedge clk); #1;
    chk("pi_end_in_end", int'(pi_end), 1);
    chk("busy_in_end", int'(busy), 1);
    chk("sched_done_pre", int'(sched_done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pi_end_held", int'(pi_end), 1);
    oem_finish = 1'b1;
    @(posedge clk); #1;
    oem_finish = 1'b0;
    chk("sched_done", int'(sched_done), 1);
    chk("pi_end_done", int'(pi_end), 1);
    chk("busy_done", int'(busy), 0);
    req = 4'b1111; ng = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (gnt != 0) ng++;
    end
    req = '0;
    chk("no_gnt_in_done", ng, 0);
    do_reset("rst_done");
    req = 4'b1000; push(3); wait_gnt(); req = '0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_burst_busy", int'(busy), 1);
    do_reset("rst_mid");
    req = 4'b1111; push(0); wait_gnt(); req = '0; wait_idle();
`ifdef STI_SCHED_WDOG_EN
    wdog_mode = 1'b1; ser_en = 1'b0;
    req = 4'b0100; push(2); wait_gnt(); req = '0; wait_idle();
    repeat (2) @(posedge clk);
    #1;
    wdog_mode = 1'b0; ser_en = 1'b1;
    chk("wdog_err_sticky", int'(wdog_err), 1);
    req = 4'b1100; push(3); wait_gnt(); req = '0; wait_idle();
    chk("wdog_err_after", int'(wdog_err), 1);
`endif
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
